// File: rtl/cam_param_pkg.sv
// Shared constants for the parameterised CAM: default geometry and learn status codes.
package cam_param_pkg;

    localparam int CAM_DATA_W = 16;
    localparam int CAM_DEPTH  = 16;

    typedef enum logic [1:0] {
        LRN_INSERTED = 2'b00,
        LRN_PRESENT  = 2'b01,
        LRN_FULL     = 2'b10,
        LRN_COLLIDE  = 2'b11
    } lrn_status_e;

endpackage

// File: rtl/cam_param_if.sv
// Request/result bundle between the CAM and its client; the client drives the master side.
interface cam_param_if
    import cam_param_pkg::*;
#(
    parameter int DATA_W = CAM_DATA_W,
    parameter int DEPTH  = CAM_DEPTH
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_care;
    logic              inv_en;
    logic [ADDR_W-1:0] inv_addr;
    logic              search_en;
    logic [DATA_W-1:0] search_data;
    logic              learn_en;
    logic [DATA_W-1:0] learn_data;

    logic              srch_vld;
    logic              match;
    logic              multi_match;
    logic [DEPTH-1:0]  match_onehot;
    logic [ADDR_W-1:0] match_addr;
    logic              learn_vld;
    logic [1:0]        learn_status;
    logic [ADDR_W-1:0] learn_addr;
    logic              full;
    logic [ADDR_W:0]   used_count;

    modport master (
        output wr_en, wr_addr, wr_data, wr_care, inv_en, inv_addr,
               search_en, search_data, learn_en, learn_data,
        input  srch_vld, match, multi_match, match_onehot, match_addr,
               learn_vld, learn_status, learn_addr, full, used_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_care, inv_en, inv_addr,
               search_en, search_data, learn_en, learn_data,
        output srch_vld, match, multi_match, match_onehot, match_addr,
               learn_vld, learn_status, learn_addr, full, used_count
    );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder; o_idx is 0 when nothing is set.
module cam_prio_enc #(
    parameter  int N = 16,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = W'(i);
        end
        o_any = |i_vec;
    end

endmodule

// File: rtl/cam_param.sv
// Ternary CAM with per-entry valid bits, registered search/learn results and occupancy count.
module cam_param
    import cam_param_pkg::*;
#(
    parameter int DATA_W = CAM_DATA_W,
    parameter int DEPTH  = CAM_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    cam_param_if.slave   bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] r_key  [DEPTH];
    logic [DATA_W-1:0] r_care [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [CNT_W-1:0]  r_count;

    logic              r_srch_vld;
    logic              r_match;
    logic              r_multi;
    logic [DEPTH-1:0]  r_onehot;
    logic [ADDR_W-1:0] r_match_addr;
    logic              r_lrn_vld;
    lrn_status_e       r_lrn_status;
    logic [ADDR_W-1:0] r_lrn_addr;

    logic [DEPTH-1:0]  w_srch_hit;
    logic [DEPTH-1:0]  w_lrn_hit;
    logic [ADDR_W-1:0] w_srch_idx;
    logic [ADDR_W-1:0] w_lrn_idx;
    logic [ADDR_W-1:0] w_free_idx;
    logic              w_srch_any;
    logic              w_lrn_any;
    logic              w_free_any;
    logic              w_srch_multi;
    logic              w_full;
    logic              w_inv_eff;
    logic              w_collide;
    logic              w_lrn_ins;
    logic              w_wr_new;
    logic              w_inv_old;
    lrn_status_e       w_lrn_status;
    logic [ADDR_W-1:0] w_lrn_addr;

    // Both compare arrays look at pre-edge contents, so same-cycle updates stay invisible.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign w_srch_hit[g] = r_valid[g] &&
                               (((r_key[g] ^ bus.search_data) & r_care[g]) == '0);
        assign w_lrn_hit[g]  = r_valid[g] &&
                               (((r_key[g] ^ bus.learn_data) & r_care[g]) == '0);
    end

    cam_prio_enc #(.N(DEPTH)) u_srch_enc (
        .i_vec (w_srch_hit),
        .o_idx (w_srch_idx),
        .o_any (w_srch_any)
    );

    cam_prio_enc #(.N(DEPTH)) u_lrn_enc (
        .i_vec (w_lrn_hit),
        .o_idx (w_lrn_idx),
        .o_any (w_lrn_any)
    );

    cam_prio_enc #(.N(DEPTH)) u_free_enc (
        .i_vec (~r_valid),
        .o_idx (w_free_idx),
        .o_any (w_free_any)
    );

    assign w_srch_multi = |(w_srch_hit & (w_srch_hit - DEPTH'(1)));
    assign w_full       = (r_count == CNT_W'(DEPTH));

    // A write to the same slot overrides the invalidate.
    assign w_inv_eff = bus.inv_en && !(bus.wr_en && (bus.wr_addr == bus.inv_addr));
    assign w_collide = bus.wr_en || bus.inv_en;
    assign w_lrn_ins = bus.learn_en && !w_collide && !w_lrn_any && w_free_any;
    assign w_wr_new  = bus.wr_en && !r_valid[bus.wr_addr];
    assign w_inv_old = w_inv_eff && r_valid[bus.inv_addr];

    always_comb begin
        w_lrn_status = LRN_INSERTED;
        w_lrn_addr   = w_free_idx;
        if (w_collide) begin
            w_lrn_status = LRN_COLLIDE;
            w_lrn_addr   = '0;
        end else if (w_lrn_any) begin
            w_lrn_status = LRN_PRESENT;
            w_lrn_addr   = w_lrn_idx;
        end else if (w_full) begin
            w_lrn_status = LRN_FULL;
            w_lrn_addr   = '0;
        end
    end

    // Key/care storage is deliberately left unreset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.wr_en) begin
                r_key[bus.wr_addr]  <= bus.wr_data;
                r_care[bus.wr_addr] <= bus.wr_care;
            end else if (w_lrn_ins) begin
                r_key[w_free_idx]  <= bus.learn_data;
                r_care[w_free_idx] <= '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            if (w_inv_eff) r_valid[bus.inv_addr] <= 1'b0;
            if (bus.wr_en) r_valid[bus.wr_addr]  <= 1'b1;
            if (w_lrn_ins) r_valid[w_free_idx]   <= 1'b1;
            r_count <= r_count + CNT_W'(w_wr_new) + CNT_W'(w_lrn_ins) - CNT_W'(w_inv_old);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_srch_vld   <= 1'b0;
            r_match      <= 1'b0;
            r_multi      <= 1'b0;
            r_onehot     <= '0;
            r_match_addr <= '0;
            r_lrn_vld    <= 1'b0;
            r_lrn_status <= LRN_INSERTED;
            r_lrn_addr   <= '0;
        end else begin
            r_srch_vld   <= bus.search_en;
            r_match      <= bus.search_en && w_srch_any;
            r_multi      <= bus.search_en && w_srch_multi;
            r_onehot     <= bus.search_en ? w_srch_hit : '0;
            r_match_addr <= bus.search_en ? w_srch_idx : '0;
            r_lrn_vld    <= bus.learn_en;
            r_lrn_status <= bus.learn_en ? w_lrn_status : LRN_INSERTED;
            r_lrn_addr   <= bus.learn_en ? w_lrn_addr : '0;
        end
    end

    assign bus.srch_vld     = r_srch_vld;
    assign bus.match        = r_match;
    assign bus.multi_match  = r_multi;
    assign bus.match_onehot = r_onehot;
    assign bus.match_addr   = r_match_addr;
    assign bus.learn_vld    = r_lrn_vld;
    assign bus.learn_status = r_lrn_status;
    assign bus.learn_addr   = r_lrn_addr;
    assign bus.full         = w_full;
    assign bus.used_count   = r_count;

endmodule

// File: tb/tb_cam_param.sv
// Scoreboard bench for cam_param: a behavioural table model predicts search/learn results.
module tb_cam_param;
    import cam_param_pkg::*;

    localparam int DW = 16;
    localparam int DP = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cam_param_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
    cam_param #(.DATA_W(DW), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [DP-1:0] oh;
        logic [AW-1:0] addr;
        logic          multi;
    } srch_exp_t;

    typedef struct {
        logic [1:0]    st;
        logic [AW-1:0] addr;
    } lrn_exp_t;

    srch_exp_t sq[$];
    lrn_exp_t  lq[$];
    srch_exp_t mse;
    lrn_exp_t  mle;

    logic [DW-1:0] mkey  [DP];
    logic [DW-1:0] mcare [DP];
    logic [DP-1:0] mval;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DP-1:0] m_hit(input logic [DW-1:0] d);
        logic [DP-1:0] r = '0;
        for (int i = 0; i < DP; i++)
            if (mval[i] && (((mkey[i] ^ d) & mcare[i]) == '0)) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [AW-1:0] m_low(input logic [DP-1:0] v);
        for (int i = 0; i < DP; i++)
            if (v[i]) return AW'(i);
        return '0;
    endfunction

    function automatic int m_pop(input logic [DP-1:0] v);
        int n = 0;
        for (int i = 0; i < DP; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic idle();
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_care = 0;
        bus.inv_en = 0; bus.inv_addr = 0;
        bus.search_en = 0; bus.search_data = 0;
        bus.learn_en = 0; bus.learn_data = 0;
    endtask

    // One clock of stimulus: predict results from the model, update it, then check occupancy.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [DW-1:0] wc, input logic ie, input logic [AW-1:0] ia,
                       input logic se, input logic [DW-1:0] sd,
                       input logic le, input logic [DW-1:0] ld);
        logic [DP-1:0] h;
        logic          ins = 1'b0;
        logic [AW-1:0] f = '0;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_care = wc;
        bus.inv_en = ie; bus.inv_addr = ia;
        bus.search_en = se; bus.search_data = sd;
        bus.learn_en = le; bus.learn_data = ld;
        if (se) begin
            h = m_hit(sd);
            sq.push_back('{oh: h, addr: m_low(h), multi: (m_pop(h) > 1)});
        end
        if (le) begin
            h = m_hit(ld);
            if (we || ie)            lq.push_back('{st: 2'b11, addr: '0});
            else if (h != '0)        lq.push_back('{st: 2'b01, addr: m_low(h)});
            else if (m_pop(mval) == DP) lq.push_back('{st: 2'b10, addr: '0});
            else begin
                f = m_low(~mval);
                ins = 1'b1;
                lq.push_back('{st: 2'b00, addr: f});
            end
        end
        if (ie && !(we && wa == ia)) mval[ia] = 1'b0;
        if (we) begin mkey[wa] = wd; mcare[wa] = wc; mval[wa] = 1'b1; end
        if (ins) begin mkey[f] = ld; mcare[f] = '1; mval[f] = 1'b1; end
        @(posedge clk); #1;
        idle();
        chk("used_count", bus.used_count, m_pop(mval));
        chk("full", bus.full, m_pop(mval) == DP);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] c);
        cyc(1, a, d, c, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic inv(input logic [AW-1:0] a);
        cyc(0, 0, 0, 0, 1, a, 0, 0, 0, 0);
    endtask
    task automatic srch(input logic [DW-1:0] d);
        cyc(0, 0, 0, 0, 0, 0, 1, d, 0, 0);
    endtask
    task automatic lrn(input logic [DW-1:0] d);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, d);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_srch"}, {bus.srch_vld, bus.match, bus.multi_match,
                             bus.match_onehot, bus.match_addr}, 0);
        chk({tag, "_lrn"}, {bus.learn_vld, bus.learn_status, bus.learn_addr}, 0);
        chk({tag, "_occ"}, {bus.full, bus.used_count}, 0);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.srch_vld) begin
                if (sq.size() == 0) chk("srch_spurious", 1, 0);
                else begin
                    mse = sq.pop_front();
                    chk("srch_onehot", bus.match_onehot, mse.oh);
                    chk("srch_match", bus.match, mse.oh != '0);
                    chk("srch_multi", bus.multi_match, mse.multi);
                    chk("srch_addr", bus.match_addr, mse.addr);
                end
            end else begin
                chk("srch_idle", {bus.match, bus.multi_match, bus.match_onehot, bus.match_addr}, 0);
            end
            if (bus.learn_vld) begin
                if (lq.size() == 0) chk("lrn_spurious", 1, 0);
                else begin
                    mle = lq.pop_front();
                    chk("lrn_status", bus.learn_status, mle.st);
                    chk("lrn_addr", bus.learn_addr, mle.addr);
                end
            end
        end
    end

    initial begin
        idle();
        mval = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        // Request during reset must be dropped.
        bus.search_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_drop", bus.srch_vld, 0);
        rst = 1'b0;
        idle();
        mon_on = 1'b1;

        // 1: duplicate keys give multi-match
        wr(0, 16'h1234, 16'hFFFF);
        wr(1, 16'h5678, 16'hFFFF);
        wr(2, 16'h9ABC, 16'hFFFF);
        wr(3, 16'h9ABC, 16'hFFFF);
        srch(16'h9ABC);
        chk("t1_vld", bus.srch_vld, 1);
        chk("t1_onehot", bus.match_onehot, 16'h000C);
        chk("t1_multi", bus.multi_match, 1);
        chk("t1_addr", bus.match_addr, 2);
        chk("t1_count", bus.used_count, 4);

        // 2: ternary entry
        wr(5, 16'hAB00, 16'hFF00);
        srch(16'hABCD);
        chk("t2_onehot", bus.match_onehot, 16'h0020);
        chk("t2_addr", bus.match_addr, 5);
        chk("t2_multi", bus.multi_match, 0);
        srch(16'hAC00);
        chk("t2_nomatch", {bus.match, bus.match_addr}, 0);

        // 3: invalidate and write/invalidate collision
        inv(2);
        chk("t3_count", bus.used_count, 4);
        srch(16'h9ABC);
        chk("t3_onehot", bus.match_onehot, 16'h0008);
        chk("t3_addr", bus.match_addr, 3);
        cyc(1, 3, 16'h9ABC, 16'hFFFF, 1, 3, 0, 0, 0, 0);
        chk("t3_wr_wins", bus.used_count, 4);
        srch(16'h9ABC);
        chk("t3_still_valid", bus.match_onehot, 16'h0008);

        // 4: learn
        lrn(16'h5678);
        chk("t4_present", {bus.learn_status, bus.learn_addr}, {2'b01, 4'd1});
        lrn(16'h7777);
        chk("t4_insert", {bus.learn_status, bus.learn_addr}, {2'b00, 4'd2});
        chk("t4_count", bus.used_count, 5);
        cyc(1, 4, 16'h4000, 16'hFFFF, 0, 0, 0, 0, 1, 16'h8888);
        chk("t4_collide", {bus.learn_status, bus.learn_addr}, {2'b11, 4'd0});
        srch(16'h8888);
        srch(16'h7777);
        chk("t4_learned", bus.match_addr, 2);

        // 5: fill, full learn, net wr/inv change, concurrent search+learn
        chk("t5_not_full", bus.full, 0);
        for (int i = 0; i < DP; i++)
            if (!mval[i]) wr(AW'(i), 16'hC000 + 16'(i), 16'hFFFF);
        chk("t5_full", bus.full, 1);
        chk("t5_count", bus.used_count, 16);
        lrn(16'h4444);
        chk("t5_lrn_full", {bus.learn_status, bus.learn_addr}, {2'b10, 4'd0});
        chk("t5_count_hold", bus.used_count, 16);
        cyc(1, 14, 16'hD00D, 16'hFFFF, 1, 15, 0, 0, 0, 0);
        chk("t5_net", bus.used_count, 15);
        cyc(0, 0, 0, 0, 0, 0, 1, 16'h4444, 1, 16'h4444);
        chk("t5_sl_srch", bus.match, 0);
        chk("t5_sl_lrn", {bus.learn_status, bus.learn_addr}, {2'b00, 4'd15});
        srch(16'h4444);
        chk("t5_sl_after", bus.match_addr, 15);

        // 6: search sees pre-write contents
        cyc(1, 0, 16'h0000, 16'hFFFF, 0, 0, 1, 16'h1234, 0, 0);
        chk("t6_old", {bus.match, bus.match_addr}, {1'b1, 4'd0});
        srch(16'h1234);
        chk("t6_new", bus.match, 0);

        // Random mix with small key space to hit collisions and partial matches
        for (int n = 0; n < 200; n++) begin
            logic [DW-1:0] c;
            case ($urandom_range(0, 2))
                0: c = 16'hFFFF;
                1: c = 16'hFF00;
                default: c = 16'h0F0F;
            endcase
            cyc($urandom_range(0, 3) == 0, AW'($urandom_range(0, 15)),
                16'h1111 * 16'($urandom_range(0, 7)), c,
                $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, 16'h1111 * 16'($urandom_range(0, 7)),
                $urandom_range(0, 2) == 0, 16'h1111 * 16'($urandom_range(0, 7)));
        end

        // Mid-stream reset with a request in the reset cycle
        rst = 1'b1;
        bus.search_en = 1'b1;
        bus.search_data = 16'h1234;
        bus.learn_en = 1'b1;
        bus.learn_data = 16'h9999;
        @(posedge clk); #1;
        chk_all_zero("midreset");
        rst = 1'b0;
        idle();
        mval = '0;
        srch(16'h1234);
        chk("post_reset", {bus.srch_vld, bus.match}, {1'b1, 1'b0});

        repeat (2) @(negedge clk);
        chk("sq_drained", sq.size(), 0);
        chk("lq_drained", lq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
